// File: rtl/dsram_responder.sv
// dsram_responder: byte-lane-writable data SRAM with WAIT_CYCLES wait states and stall back-pressure.
// Define DSRAM_ADDR_CHECK_EN to flag out-of-range addresses through bus_error.
module dsram_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        bus_error
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_d;
    logic [3:0] cnt, cnt_d;
    logic [31:0] mem [1 << (ADDR_WIDTH - 2)];
    logic [ADDR_WIDTH-3:0] a_idx, c_idx;
    logic [3:0] a_wen, c_wen;
    logic [31:0] a_wdata, c_wdata, mask, merged;
    logic c_oor, go_resp, unused_addr;
    assign unused_addr = ^{mem_addr[31:ADDR_WIDTH], mem_addr[1:0]};
    assign mem_stall = (state == IDLE && mem_en) || state == WAIT;
    always_comb begin
        state_d = state;
        cnt_d = cnt;
        case (state)
            IDLE: if (mem_en) begin
                state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
                cnt_d = 4'(WAIT_CYCLES - 1);
            end
            WAIT: begin
                state_d = cnt == 4'd0 ? RESP : WAIT;
                cnt_d = cnt == 4'd0 ? cnt : cnt - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    assign go_resp = state_d == RESP;
    // A zero-wait access commits on the accepting edge, so it must see the live inputs.
    assign c_idx = state == IDLE ? mem_addr[ADDR_WIDTH-1:2] : a_idx;
    assign c_wen = state == IDLE ? mem_wen : a_wen;
    assign c_wdata = state == IDLE ? mem_wdata : a_wdata;
    assign mask = {{8{c_wen[3]}}, {8{c_wen[2]}}, {8{c_wen[1]}}, {8{c_wen[0]}}};
    assign merged = (mem[c_idx] & ~mask) | (c_wdata & mask);
`ifdef DSRAM_ADDR_CHECK_EN
    logic a_oor;
    always_ff @(posedge clk)
        if (state == IDLE && mem_en) a_oor <= |mem_addr[31:ADDR_WIDTH];
    assign c_oor = state == IDLE ? |mem_addr[31:ADDR_WIDTH] : a_oor;
`else
    assign c_oor = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            mem_rdata <= '0;
            bus_error <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            if (go_resp) mem_rdata <= c_oor ? '0 : merged;
            bus_error <= go_resp & c_oor;
        end
    end
    always_ff @(posedge clk) begin
        if (state == IDLE && mem_en) begin
            a_idx <= mem_addr[ADDR_WIDTH-1:2];
            a_wen <= mem_wen;
            a_wdata <= mem_wdata;
        end
    end
    always_ff @(posedge clk)
        if (!rst && go_resp && !c_oor) mem[c_idx] <= merged;
endmodule

// File: tb/tb_dsram_responder.sv
// tb_dsram_responder: scoreboard bench over three responders (WAIT_CYCLES 1, 0, 3).
module tb_dsram_responder;
    typedef struct packed {logic [31:0] d; logic e;} exp_t;
    logic clk = 0, rst = 1;
    logic [2:0] en = '0, stall, berr;
    logic [3:0] wen [3];
    logic [31:0] addr [3], wdata [3], rdata [3];
    int total = 0, bad = 0;
    int wc [3] = '{1, 0, 3};
    exp_t q0 [$], q1 [$], q2 [$];
    logic [2:0] ps = '0;
    logic pr = 1'b1;
`ifdef DSRAM_ADDR_CHECK_EN
    localparam logic [31:0] OOR_D = 32'h0, LOW_D = 32'hCAFE_F00D;
    localparam logic OOR_E = 1'b1;
`else
    localparam logic [31:0] OOR_D = 32'h5555_AAAA, LOW_D = 32'h5555_AAAA;
    localparam logic OOR_E = 1'b0;
`endif
    always #5 clk = ~clk;
    dsram_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(1)) u0 (.clk(clk), .rst(rst), .mem_en(en[0]),
        .mem_wen(wen[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]),
        .mem_stall(stall[0]), .bus_error(berr[0]));
    dsram_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) u1 (.clk(clk), .rst(rst), .mem_en(en[1]),
        .mem_wen(wen[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]),
        .mem_stall(stall[1]), .bus_error(berr[1]));
    dsram_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) u2 (.clk(clk), .rst(rst), .mem_en(en[2]),
        .mem_wen(wen[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_rdata(rdata[2]),
        .mem_stall(stall[2]), .bus_error(berr[2]));
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask
    // A response is a stall-high cycle followed by stall low, unless reset intervened.
    always @(negedge clk) begin
        exp_t e;
        logic got;
        for (int k = 0; k < 3; k++) begin
            if (ps[k] && !stall[k] && !pr) begin
                got = 1'b1;
                e = '0;
                case (k)
                    0: if (q0.size() > 0) e = q0.pop_front(); else got = 1'b0;
                    1: if (q1.size() > 0) e = q1.pop_front(); else got = 1'b0;
                    default: if (q2.size() > 0) e = q2.pop_front(); else got = 1'b0;
                endcase
                chk($sformatf("resp_present dut%0d", k), 32'(got), 32'd1);
                if (got) begin
                    chk($sformatf("rdata dut%0d", k), rdata[k], e.d);
                    chk($sformatf("bus_error dut%0d", k), 32'(berr[k]), 32'(e.e));
                end
            end
        end
        ps <= stall;
        pr <= rst;
    end
    task automatic access(input int k, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] xd, input logic xe, input logic [31:0] alt);
        exp_t e;
        int n;
        e.d = xd;
        e.e = xe;
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
        en[k] = 1'b1;
        wen[k] = w;
        addr[k] = a;
        wdata[k] = d;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall[k]) break;
            n++;
            if (n == 2) addr[k] = alt;
        end
        chk($sformatf("stall_cycles dut%0d addr %h", k, a), 32'(n), 32'(wc[k] + 1));
        @(posedge clk);
        #1;
        en[k] = 1'b0;
        wen[k] = '0;
    endtask
    initial begin
        for (int k = 0; k < 3; k++) begin
            wen[k] = '0;
            addr[k] = '0;
            wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset rdata dut%0d", k), rdata[k], 32'h0);
            chk($sformatf("reset stall dut%0d", k), 32'(stall[k]), 32'h0);
            chk($sformatf("reset bus_error dut%0d", k), 32'(berr[k]), 32'h0);
        end
        @(posedge clk);
        #1;
        access(0, 4'hF, 32'h40, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h40);
        access(0, 4'h0, 32'h40, 32'h0, 32'h1234_5678, 1'b0, 32'h40);
        access(0, 4'b0100, 32'h40, 32'h00AB_0000, 32'h12AB_5678, 1'b0, 32'h40);
        access(0, 4'h0, 32'h40, 32'h0, 32'h12AB_5678, 1'b0, 32'h40);
        access(0, 4'hF, 32'h44, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'h44);
        access(0, 4'h0, 32'h40, 32'h0, 32'h12AB_5678, 1'b0, 32'h44);
        access(0, 4'b0001, 32'h44, 32'h0000_0011, 32'hDEAD_BE11, 1'b0, 32'h44);
        access(0, 4'b1010, 32'h44, 32'h7700_6600, 32'h77AD_6611, 1'b0, 32'h44);
        access(0, 4'h0, 32'h43, 32'h0, 32'h12AB_5678, 1'b0, 32'h43);
        access(0, 4'hF, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 32'h0);
        access(0, 4'hF, 32'h1000, 32'h5555_AAAA, OOR_D, OOR_E, 32'h1000);
        @(negedge clk);
        chk("bus_error after resp", 32'(berr[0]), 32'h0);
        @(posedge clk);
        #1;
        access(0, 4'h0, 32'h0, 32'h0, LOW_D, 1'b0, 32'h0);
        access(1, 4'hF, 32'h10, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 32'h10);
        access(1, 4'h0, 32'h10, 32'h0, 32'h0BAD_F00D, 1'b0, 32'h10);
        access(1, 4'h0, 32'h10, 32'h0, 32'h0BAD_F00D, 1'b0, 32'h10);
        access(1, 4'hF, 32'h14, 32'h1111_1111, 32'h1111_1111, 1'b0, 32'h14);
        access(1, 4'b0011, 32'h14, 32'h0000_1234, 32'h1111_1234, 1'b0, 32'h14);
        access(2, 4'hF, 32'h80, 32'h0, 32'h0, 1'b0, 32'h80);
        access(2, 4'hF, 32'h84, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 32'h84);
        access(2, 4'h0, 32'h84, 32'h0, 32'hA5A5_A5A5, 1'b0, 32'h84);
        en[2] = 1'b1;
        wen[2] = 4'hF;
        addr[2] = 32'h80;
        wdata[2] = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        en[2] = 1'b0;
        wen[2] = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst mid stall", 32'(stall[2]), 32'h0);
        chk("rst mid rdata", rdata[2], 32'h0);
        @(posedge clk);
        #1;
        access(2, 4'h0, 32'h80, 32'h0, 32'h0, 1'b0, 32'h80);
        access(2, 4'h0, 32'h84, 32'h0, 32'hA5A5_A5A5, 1'b0, 32'h84);
        repeat (5) @(posedge clk);
        chk("q0 leftover", 32'(q0.size()), 32'h0);
        chk("q1 leftover", 32'(q1.size()), 32'h0);
        chk("q2 leftover", 32'(q2.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dsram_responder.md
# dsram_responder

Synchronous data-SRAM responder serving the memory stage's SRAM port (`mem_en`/`mem_wen`/`mem_addr`/`mem_wdata` in, `mem_rdata` out). It holds a byte-lane-writable word array and models a configurable number of wait states. It back-pressures the pipeline through `mem_stall` until each access completes. It sits between the memory stage and the top level, replacing the ideal zero-latency SRAM.

## Interface
- `ADDR_WIDTH`, 12: byte-address bits decoded. Array depth is 2^(ADDR_WIDTH-2) words. Legal range 3..20.
- `WAIT_CYCLES`, 1: extra stall cycles per access. Legal range 0..15.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `mem_en`  in  1  access request.
- `mem_wen`  in  4  byte write enables. Bit i writes `mem_wdata[8i+7:8i]`. 4'b0000 means read.
- `mem_addr`  in  32  byte address. Word index is `mem_addr[ADDR_WIDTH-1:2]`; bits [1:0] are ignored.
- `mem_wdata`  in  32  write data, lane-aligned by the requester.
- `mem_rdata`  out  32  registered read data.
- `mem_stall`  out  1  requester must hold and not advance while high.
- `bus_error`  out  1  out-of-range access flag (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP. Cycle counter is 4 bits wide.
- **IDLE**:
  - If `mem_en`=0: `mem_stall`=0.
  - If `mem_en`=1: `mem_stall`=1 (combinational). Latch addr/wen/wdata.
  - Next state: if WAIT_CYCLES=0, go to RESP. Otherwise go to WAIT with counter loaded to WAIT_CYCLES-1.
- **WAIT**:
  - `mem_stall`=1.
  - If counter=0, go to RESP; otherwise decrement the counter.
  - Requester input changes during WAIT are ignored; the latched values are used.
- **Commit**: on the edge entering RESP, the latched word is read-modify-written. Only lanes with latched wen=1 are updated.
- **RESP**:
  - `mem_rdata` is loaded on the edge entering RESP. It holds the post-write word at the latched index, so a partial store returns the merged word.
  - `mem_stall`=0 and `mem_rdata` is valid.
  - Next state is always IDLE. `mem_en` seen in RESP is the same, now-completing request and is not accepted.
- `mem_rdata` holds its value in all other states.
- **Reset**:
  - `rst`=1 forces IDLE and clears the counter.
  - Output reset values: `mem_rdata`=0, `mem_stall`=0, `bus_error`=0.
  - An access still in IDLE or WAIT is dropped and its write is never committed.
  - Array contents are not cleared.
- `rst` takes priority over all other events in the same cycle.

## Timing
- Request accepted in IDLE at cycle N.
- `mem_stall` is high in cycles N..N+WAIT_CYCLES.
- RESP occurs at cycle N+WAIT_CYCLES+1, with `mem_rdata` valid and stall low.
- A back-to-back request is accepted at N+WAIT_CYCLES+2 at the earliest.
- One access costs WAIT_CYCLES+2 cycles. No more than one access is ever outstanding.
- `mem_stall` depends combinationally on `mem_en` only in IDLE. There are no other combinational input-to-output paths.

## Configuration
- Macro `DSRAM_ADDR_CHECK_EN`.
- **Defined**:
  - An access with `mem_addr[31:ADDR_WIDTH]` ≠ 0 has identical timing to any other access.
  - Its write is suppressed and `mem_rdata` is loaded with 0.
  - `bus_error` is 1 during that RESP cycle only and 0 otherwise.
- **Undefined**:
  - Upper address bits are ignored, so addresses alias modulo 2^ADDR_WIDTH.
  - `bus_error` is tied to 0.

## Test plan
- **Full-word write, then read** (WAIT_CYCLES=1): write 32'h1234_5678 to 0x40, wen 4'b1111, then read 0x40.
  - Stall high for 2 cycles per access.
  - Read RESP shows 32'h1234_5678.
- **Byte merge**: 0x40 holds 32'h1234_5678; write wdata 32'h00AB_0000 with wen 4'b0100.
  - RESP `mem_rdata`=32'h12AB_5678.
- **Zero wait** (WAIT_CYCLES=0): a read of a preloaded word.
  - Stall for 1 cycle, data valid the next cycle.
  - Consecutive reads are accepted every 2 cycles.
- **Reset mid-access** (WAIT_CYCLES=3): assert `rst` in the 2nd WAIT cycle of a write of 32'hFFFF_FFFF to 0x80, where 0x80 held 0.
  - Next cycle: stall=0, `mem_rdata`=0.
  - A subsequent read of 0x80 returns 0.
- **Input instability**: change `mem_addr` from 0x40 to 0x44 during WAIT.
  - The response reflects 0x40.
- **Out-of-range address** with `DSRAM_ADDR_CHECK_EN` (ADDR_WIDTH=12): write to 0x1000.
  - `bus_error`=1 in RESP, `mem_rdata`=0.
  - A read of 0x0000 is unchanged.
  - Without the macro, the same write lands at 0x0000.
